// File: rtl/nonce_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : nonce_dispatcher
//  Purpose  : Round-robin chunked nonce-space scheduler for NUM_MINERS cores;
//             latches the first winning nonce. DISPATCH_STATS_EN builds the
//             per-job grant counter (chunks_issued), otherwise tied to zero.
//  Revision : 1.0
// ============================================================================
module nonce_dispatcher #(
    parameter int NUM_MINERS = 4,
    parameter int CHUNK_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NUM_MINERS-1:0]    req,
    input  logic [NUM_MINERS-1:0]    found,
    input  logic [32*NUM_MINERS-1:0] found_nonce,
    output logic [NUM_MINERS-1:0]    grant,
    output logic [31:0]              grant_base,
    output logic                     busy,
    output logic                     done,
    output logic                     success,
    output logic [31:0]              nonce_out,
    output logic [31:0]              chunks_issued
);

    localparam int               PTR_W      = (NUM_MINERS > 1) ? $clog2(NUM_MINERS) : 1;
    localparam logic [31:0]      CHUNK_SIZE = 32'd1 << CHUNK_BITS;
    localparam logic [31:0]      LAST_BASE  = 32'd0 - CHUNK_SIZE;
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(NUM_MINERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    start_prev_q, start_prev_d;
    logic [31:0]             next_base_q, next_base_d;
    logic [NUM_MINERS-1:0]   active_q, active_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_MINERS-1:0]   grant_q, grant_d;
    logic [31:0]             grant_base_q, grant_base_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    success_q, success_d;
    logic [31:0]             nonce_out_q, nonce_out_d;
`ifdef DISPATCH_STATS_EN
    logic [31:0]             chunks_q, chunks_d;
`endif

    logic [NUM_MINERS-1:0]   eff_req;
    logic                    rr_hit;
    logic [PTR_W-1:0]        rr_idx;
    logic                    found_any;
    logic [31:0]             found_sel;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_MINERS) begin
            sum = sum - NUM_MINERS;
        end
        return PTR_W'(sum);
    endfunction

    // A request still visible during its own grant cycle is stale and must not count.
    always_comb begin
        eff_req = req & ~grant_q;
        rr_hit  = 1'b0;
        rr_idx  = '0;
        for (int k = 0; k < NUM_MINERS; k++) begin
            if (!rr_hit && eff_req[wrap_add(rr_ptr_q, k)]) begin
                rr_hit = 1'b1;
                rr_idx = wrap_add(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        found_any = |found;
        found_sel = '0;
        for (int k = NUM_MINERS - 1; k >= 0; k--) begin
            if (found[k]) begin
                found_sel = found_nonce[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        start_prev_d = start;
        next_base_d  = next_base_q;
        active_d     = active_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = '0;
        grant_base_d = grant_base_q;
        success_d    = success_q;
        nonce_out_d  = nonce_out_q;
`ifdef DISPATCH_STATS_EN
        chunks_d     = chunks_q;
`endif

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !start_prev_q) begin
                        state_d     = ST_DISPATCH;
                        next_base_d = '0;
                        active_d    = '0;
                        success_d   = 1'b0;
                        nonce_out_d = '0;
`ifdef DISPATCH_STATS_EN
                        chunks_d    = '0;
`endif
                    end
                end
                ST_DISPATCH: begin
                    if (!start) begin
                        state_d = ST_IDLE;
                    end else if (found_any) begin
                        state_d     = ST_DONE;
                        success_d   = 1'b1;
                        nonce_out_d = found_sel;
                    end else begin
                        active_d = active_q & ~eff_req;
                        if (rr_hit) begin
                            grant_d[rr_idx]  = 1'b1;
                            active_d[rr_idx] = 1'b1;
                            grant_base_d     = next_base_q;
                            next_base_d      = next_base_q + CHUNK_SIZE;
                            rr_ptr_d         = (rr_idx == LAST_PTR) ? '0 : rr_idx + 1'b1;
`ifdef DISPATCH_STATS_EN
                            if (chunks_q != 32'hFFFF_FFFF) begin
                                chunks_d = chunks_q + 32'd1;
                            end
`endif
                            // The top chunk ends the job; the base never wraps to 0.
                            if (next_base_q == LAST_BASE) begin
                                state_d = ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!start) begin
                        state_d = ST_IDLE;
                    end else if (found_any) begin
                        state_d     = ST_DONE;
                        success_d   = 1'b1;
                        nonce_out_d = found_sel;
                    end else begin
                        active_d = active_q & ~eff_req;
                        if (active_q == '0) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_DISPATCH) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            next_base_q  <= '0;
            active_q     <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            grant_base_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            success_q    <= 1'b0;
            nonce_out_q  <= '0;
`ifdef DISPATCH_STATS_EN
            chunks_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            next_base_q  <= next_base_d;
            active_q     <= active_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            grant_base_q <= grant_base_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            success_q    <= success_d;
            nonce_out_q  <= nonce_out_d;
`ifdef DISPATCH_STATS_EN
            chunks_q     <= chunks_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign grant_base = grant_base_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign success    = success_q;
    assign nonce_out  = nonce_out_q;
`ifdef DISPATCH_STATS_EN
    assign chunks_issued = chunks_q;
`else
    assign chunks_issued = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nonce_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nonce_dispatcher
//  Purpose  : Directed and randomized checks of nonce_dispatcher with
//             CHUNK_BITS=8 and CHUNK_BITS=30 instances sharing one stimulus.
//  Revision : 1.0
// ============================================================================
module tb_nonce_dispatcher;

    logic         clk;
    logic         reset;
    logic         start;
    logic         abort;
    logic [3:0]   req;
    logic [3:0]   found;
    logic [127:0] found_nonce;

    logic [3:0]   grant,      grant30;
    logic [31:0]  grant_base, grant_base30;
    logic         busy,       busy30;
    logic         done,       done30;
    logic         success,    success30;
    logic [31:0]  nonce_out,  nonce_out30;
    logic [31:0]  chunks,     chunks30;

    int checks = 0;
    int errors = 0;

    nonce_dispatcher #(.NUM_MINERS(4), .CHUNK_BITS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .req(req), .found(found), .found_nonce(found_nonce),
        .grant(grant), .grant_base(grant_base), .busy(busy), .done(done),
        .success(success), .nonce_out(nonce_out), .chunks_issued(chunks)
    );

    nonce_dispatcher #(.NUM_MINERS(4), .CHUNK_BITS(30)) dut30 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .req(req), .found(found), .found_nonce(found_nonce),
        .grant(grant30), .grant_base(grant_base30), .busy(busy30), .done(done30),
        .success(success30), .nonce_out(nonce_out30), .chunks_issued(chunks30)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        start = 1'b0; abort = 1'b0; req = '0; found = '0; found_nonce = '0;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // All four miners request at once and follow the hold-until-grant handshake.
    task automatic four_grants;
        logic [3:0] prev_g;
        logic [3:0] exp_g;
        req    = 4'b1111;
        prev_g = '0;
        for (int k = 0; k < 4; k++) begin
            tick;
            exp_g = 4'b0001 << k;
            chk($sformatf("hs%0d_grant", k), 32'(grant), 32'(exp_g));
            chk($sformatf("hs%0d_base", k), grant_base, 32'(k) * 32'h100);
            chk($sformatf("hs%0d_grant30", k), 32'(grant30), 32'(exp_g));
            chk($sformatf("hs%0d_base30", k), grant_base30, 32'(k) << 30);
            req    = req & ~prev_g;
            prev_g = exp_g;
        end
    endtask

    // Random requesters against a reference: pending set, rotating pointer, grant counter.
    task automatic rand_job(input int ncyc);
        logic [3:0]  want, gcyc, rel, expg, fm;
        logic [31:0] nonces [4];
        logic [31:0] exp_nonce;
        int rr, issued, w;
        do_reset;
        start = 1'b1;
        tick;
        want = '0; gcyc = '0; rel = '0; rr = 0; issued = 0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!want[i] && !gcyc[i] && !rel[i] && $urandom_range(0, 2) == 0) want[i] = 1'b1;
            end
            req = want | gcyc;
            tick;
            expg = '0;
            w    = 0;
            for (int k = 0; k < 4; k++) begin
                if (expg == '0 && want[(rr + k) % 4]) begin
                    w    = (rr + k) % 4;
                    expg = 4'b0001 << w;
                end
            end
            chk("rnd_grant", 32'(grant), 32'(expg));
            if (expg != '0) begin
                chk("rnd_base", grant_base, 32'(issued) * 32'h100);
                issued++;
                rr      = (w + 1) % 4;
                want[w] = 1'b0;
            end
            chk("rnd_busy", 32'(busy), 32'd1);
            rel  = gcyc;
            gcyc = expg;
        end
        fm = 4'($urandom_range(1, 15));
        exp_nonce = '0;
        for (int i = 0; i < 4; i++) begin
            nonces[i] = $urandom;
            found_nonce[32*i +: 32] = nonces[i];
        end
        for (int i = 3; i >= 0; i--) begin
            if (fm[i]) exp_nonce = nonces[i];
        end
        found = fm;
        req   = want | gcyc | 4'b0001;
        tick;
        found = '0;
        req   = '0;
        chk("rnd_found_grant", 32'(grant), 32'd0);
        chk("rnd_found_done", 32'(done), 32'd1);
        chk("rnd_found_success", 32'(success), 32'd1);
        chk("rnd_found_nonce", nonce_out, exp_nonce);
`ifdef DISPATCH_STATS_EN
        chk("rnd_chunks", chunks, 32'(issued));
`endif
        start = 1'b0;
        tick;
        chk("rnd_idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; req = '0; found = '0; found_nonce = '0;
        reset = 1'b1;
        tick;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_base", grant_base, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_success", 32'(success), 32'd0);
        chk("rst_nonce", nonce_out, 32'd0);
        chk("rst_chunks", chunks, 32'd0);
        chk("rst_busy30", 32'(busy30), 32'd0);
        reset = 1'b0;

        // Single miner, two one-shot requests
        start = 1'b1;
        tick;
        chk("t1_busy", 32'(busy), 32'd1);
        req = 4'b0001;
        tick;
        chk("t1_grant0", 32'(grant), 32'd1);
        chk("t1_base0", grant_base, 32'h0);
        req = '0;
        tick;
        chk("t1_nogrant", 32'(grant), 32'd0);
        req = 4'b0001;
        tick;
        chk("t1_grant1", 32'(grant), 32'd1);
        chk("t1_base1", grant_base, 32'h100);
        req = '0;
`ifdef DISPATCH_STATS_EN
        chk("t1_chunks", chunks, 32'd2);
`else
        chk("t1_chunks_tied", chunks, 32'd0);
`endif

        // Full rotation; the CHUNK_BITS=30 instance exhausts and drains
        do_reset;
        start = 1'b1;
        tick;
        four_grants;
        chk("t4_busy30", 32'(busy30), 32'd1);
        chk("t4_done30", 32'(done30), 32'd0);
`ifdef DISPATCH_STATS_EN
        chk("t2_chunks", chunks, 32'd4);
        chk("t4_chunks30", chunks30, 32'd4);
`endif
        req = '0;
        tick;
        chk("t4_drain_grant30", 32'(grant30), 32'd0);
        chk("t4_drain_busy30", 32'(busy30), 32'd1);
        chk("t4_drain_done30", 32'(done30), 32'd0);
        req = 4'b1111;
        tick;
        chk("t4_drain_grant30b", 32'(grant30), 32'd0);
        req = '0;
        for (int w = 0; w < 10 && !done30; w++) tick;
        chk("t4_done30_final", 32'(done30), 32'd1);
        chk("t4_success30", 32'(success30), 32'd0);
        chk("t4_busy30_final", 32'(busy30), 32'd0);
`ifdef DISPATCH_STATS_EN
        chk("t4_chunks30_held", chunks30, 32'd4);
`endif

        // Asynchronous reset between edges while a grant is showing
        do_reset;
        start = 1'b1;
        tick;
        req = 4'b0001;
        tick;
        req = '0;
        tick;
        req = 4'b0001;
        tick;
        req = '0;
        chk("t5_pre_grant", 32'(grant), 32'd1);
        chk("t5_pre_base", grant_base, 32'h100);
        #2 reset = 1'b1;
        #1;
        chk("t5_grant", 32'(grant), 32'd0);
        chk("t5_base", grant_base, 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_chunks", chunks, 32'd0);
        tick;
        reset = 1'b0;

        // Abort while draining
        do_reset;
        start = 1'b1;
        tick;
        four_grants;
        req = '0;
        tick;
        chk("t6_busy30_drain", 32'(busy30), 32'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("t6_busy30", 32'(busy30), 32'd0);
        chk("t6_done30", 32'(done30), 32'd0);

        // Two finders in one cycle with a pending request
        do_reset;
        start = 1'b1;
        tick;
        req   = 4'b0001;
        found = 4'b0110;
        found_nonce[63:32] = 32'h55;
        found_nonce[95:64] = 32'h1234;
        tick;
        req   = '0;
        found = '0;
        chk("t3_grant", 32'(grant), 32'd0);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_success", 32'(success), 32'd1);
        chk("t3_nonce", nonce_out, 32'h55);
        chk("t3_busy", 32'(busy), 32'd0);
        found = 4'b0001;
        found_nonce[31:0] = 32'hDEAD;
        tick;
        found = '0;
        chk("t3_done_held", 32'(done), 32'd1);
        chk("t3_nonce_held", nonce_out, 32'h55);
        start = 1'b0;
        tick;
        chk("t3_idle_done", 32'(done), 32'd0);
        chk("t3_idle_busy", 32'(busy), 32'd0);

        for (int j = 0; j < 4; j++) begin
            rand_job(40 + 5 * j);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
